// File: rtl/ssd_display_ctrl_pkg.sv
// ssd_display_ctrl_pkg: shared state encodings, cathode codes and BCD helpers
// for the seven-segment display sequencer.
package ssd_display_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  endfunction
  // Double-dabble correction applied before each shift.
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    for (int i = 0; i < 3; i++)
      dabble_adj[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
  endfunction
endpackage

// File: rtl/ssd_display_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: serial double-dabble converter, one bit per enabled cycle;
// last flags the cycle performing the final iteration.
module bin2bcd_seq
  import ssd_display_ctrl_pkg::*;
#(
  parameter int BIN_W = 9
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             en,
  input  logic [BIN_W-1:0] bin,
  output logic [11:0]      bcd,
  output logic             last
);
  localparam int CW = $clog2(BIN_W + 1);
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W+11:0] shifted;
  always_comb begin
    shifted = {dabble_adj(bcd_q), bin_q} << 1;
    bin_d = start ? bin : en ? shifted[BIN_W-1:0] : bin_q;
    bcd_d = start ? 12'h0 : en ? shifted[BIN_W+11:BIN_W] : bcd_q;
    cnt_d = start ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end
  assign bcd  = bcd_q;
  assign last = cnt_q == CW'(BIN_W - 1);
endmodule

// File: rtl/ssd_display_ctrl.sv
// ssd_display_ctrl: Load/Busy binary-to-BCD sequencer with atomic digit commit
// and a time-multiplexed, leading-zero-blanking 4-digit scan.
module ssd_display_ctrl
  import ssd_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 18,
  parameter int BIN_W    = 9
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [BIN_W-1:0] Value,
  input  logic             Blank_lz,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       An,
  output logic [6:0]       Cath,
  output logic             Dp
);
  state_t state_q, state_d;
  logic [15:0] digit_q, digit_d;
  logic [SCAN_DIV-1:0] cnt_q, cnt_d;
  logic [3:0] an_q, an_d;
  logic [6:0] cath_q, cath_d;
  logic [11:0] bcd;
  logic [1:0] idx;
  logic start, last, blank;
  bin2bcd_seq #(.BIN_W(BIN_W)) u_conv (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .en(state_q == S_CONV),
    .bin(Value), .bcd(bcd), .last(last)
  );
  always_comb begin
    start   = state_q == S_IDLE && Load;
    state_d = start ? S_CONV
            : (state_q == S_CONV && last) ? S_COMMIT
            : state_q == S_COMMIT ? S_IDLE : state_q;
    digit_d = state_q == S_COMMIT ? {4'h0, bcd} : digit_q;
    cnt_d   = cnt_q + 1'b1;
    idx     = cnt_q[SCAN_DIV-1 -: 2];
    // A digit is a leading zero when it and everything above it is zero.
    blank   = Blank_lz && idx != 2'd0 && (digit_q >> {idx, 2'b00}) == 16'h0;
    an_d    = ~(4'b0001 << idx);
    cath_d  = blank ? SEG_BLANK : seg(digit_q[{idx, 2'b00} +: 4]);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      digit_q <= '0;
      cnt_q   <= '0;
      an_q    <= 4'b1111;
      cath_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      cath_q  <= cath_d;
    end
  end
  assign Busy = state_q != S_IDLE;
  assign Done = state_q == S_COMMIT;
  assign An   = an_q;
  assign Cath = cath_q;
  assign Dp   = 1'b1;
endmodule

// File: tb/tb_ssd_display_ctrl.sv
// tb_ssd_display_ctrl: scoreboard bench; expected Done cycles and values are
// queued at Load time, Done timing is checked by a monitor, digits by scan walks.
module tb_ssd_display_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int BIN_W    = 9;
  localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  typedef struct {int val; int cyc;} exp_t;
  logic Clk = 0, Reset_n = 0, Load = 0, Blank_lz = 0;
  logic [BIN_W-1:0] Value = '0;
  logic Busy, Done, Dp;
  logic [3:0] An;
  logic [6:0] Cath;
  int n_chk = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  exp_t e;

  ssd_display_ctrl #(.SCAN_DIV(SCAN_DIV), .BIN_W(BIN_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .Value(Value), .Blank_lz(Blank_lz),
    .Busy(Busy), .Done(Done), .An(An), .Cath(Cath), .Dp(Dp)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic load(input int v);
    Load = 1; Value = BIN_W'(v);
    sb.push_back('{v, cyc + 10});
    tick();
    Load = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin tick(); k++; end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    tick(2);
  endtask

  task automatic wait_an(input logic [3:0] a);
    int k = 0;
    while (An !== a && k < 40) begin @(negedge Clk); k++; end
    if (An !== a) check("an_timeout", An, a);
  endtask

  // Walk one full scan from the ones slot, checking anode and cathode per slot.
  task automatic show(input int v, input logic blz);
    int pw = 1;
    logic [3:0] ea;
    logic [6:0] ec;
    Blank_lz = blz;
    tick(2);
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int i = 0; i < 4; i++) begin
      ea = ~(4'b0001 << i);
      ec = (blz && i > 0 && v < pw) ? 7'h7F : SEG_TAB[(v / pw) % 10];
      check($sformatf("an_slot%0d_v%0d", i, v), An, ea);
      check($sformatf("cath_slot%0d_v%0d_b%0d", i, v, blz), Cath, ec);
      pw *= 10;
      tick(4);
    end
  endtask

  initial begin
    int b;
    tick(3);
    check("rst_an", An, 4'b1111);
    check("rst_cath", Cath, 7'h7F);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("dp", Dp, 1);
    Reset_n = 1;
    show(0, 0);
    load(511);
    b = 0;
    repeat (14) begin @(negedge Clk); if (Busy === 1'b1) b++; end
    check("busy_cycles", b, 10);
    show(511, 0);
    load(7);
    wait_done();
    show(7, 1);
    show(7, 0);
    load(123);
    tick(2);
    Load = 1; Value = 9'd45;
    tick();
    Load = 0;
    wait_done();
    show(123, 0);
    Load = 1; Value = 9'd300;
    tick();
    Load = 0;
    tick(4);
    Reset_n = 0;
    #1;
    check("abort_an", An, 4'b1111);
    check("abort_cath", Cath, 7'h7F);
    check("abort_busy", Busy, 0);
    tick(2);
    Reset_n = 1;
    tick(20);
    show(0, 0);
    load(300);
    wait_done();
    show(300, 0);
    Load = 1; Value = 9'd10;
    sb.push_back('{10, cyc + 10});
    sb.push_back('{0, cyc + 21});
    tick();
    Value = 9'd0;
    tick(11);
    Load = 0;
    wait_done();
    show(0, 1);
    tick(20);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
